// File: rtl/axi_freq_loader.sv
// axi_freq_loader
//   AXI4-Lite initiator that takes a stream of 32-bit frequency words and
//   writes them, one transaction at a time, to consecutive word addresses
//   starting at a programmable base in the frequency selector's register
//   window. Reports completion (done pulse) and bus errors (sticky err).
//
// Build option:
//   AXI_FREQ_LOADER_READBACK_EN - when defined, every OKAY write is read
//   back from the same address and compared against the written word.
//   When undefined, the read channels are tied off.
//
// Ports:
//   m00_axi_aclk / m00_axi_aresetn  clock, async active-low reset
//   start, base_addr, word_count    sequence request (sampled in IDLE only)
//   s_data, s_valid, s_ready        word source handshake
//   busy, done, err                 status
//   m00_axi_aw* / w* / b*           AXI4-Lite write channels
//   m00_axi_ar* / r*                AXI4-Lite read channels (readback)
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | s_ready high, waiting for the next word from the source
// WRITE     | awvalid/wvalid outstanding, each drops on its own ready
// RESP      | bready high, waiting for the write response
// VERIFY_AR | (readback) arvalid high at the address just written
// VERIFY_R  | (readback) rready high, compare returned data
// FIN       | done pulse, back to IDLE

module axi_freq_loader #(
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_M00_AXI_ADDR_WIDTH = 5
) (
    input  logic                            m00_axi_aclk,
    input  logic                            m00_axi_aresetn,
    input  logic                            start,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [7:0]                      word_count,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0] s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_awaddr,
    output logic [2:0]                      m00_axi_awprot,
    output logic                            m00_axi_awvalid,
    input  logic                            m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_wdata,
    output logic [3:0]                      m00_axi_wstrb,
    output logic                            m00_axi_wvalid,
    input  logic                            m00_axi_wready,
    input  logic [1:0]                      m00_axi_bresp,
    input  logic                            m00_axi_bvalid,
    output logic                            m00_axi_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [2:0]                      m00_axi_arprot,
    output logic                            m00_axi_arvalid,
    input  logic                            m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]                      m00_axi_rresp,
    input  logic                            m00_axi_rvalid,
    output logic                            m00_axi_rready
);

    localparam int AW = C_M00_AXI_ADDR_WIDTH;
    localparam int DW = C_M00_AXI_DATA_WIDTH;

`ifdef AXI_FREQ_LOADER_READBACK_EN
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WRITE     = 3'd2,
        S_RESP      = 3'd3,
        S_VERIFY_AR = 3'd4,
        S_VERIFY_R  = 3'd5,
        S_FIN       = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WRITE = 3'd2,
        S_RESP  = 3'd3,
        S_FIN   = 3'd6
    } state_t;
`endif

    state_t          state_q;
    logic [AW-1:0]   base_q;
    logic [7:0]      count_q;
    logic [7:0]      idx_q;
    logic [AW-1:0]   awaddr_q;
    logic [DW-1:0]   wdata_q;
    logic            awvalid_q;
    logic            wvalid_q;
    logic            bready_q;
    logic            s_ready_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    logic [7:0]      idx_d;
    logic            last_d;
    logic [AW-1:0]   addr_d;

    assign idx_d  = idx_q + 8'd1;
    assign last_d = (idx_d == count_q);
    // Word offset is truncated to the address width, so the window wraps.
    assign addr_d = base_q + AW'({idx_q, 2'b00});

`ifdef AXI_FREQ_LOADER_READBACK_EN
    logic [AW-1:0]   araddr_q;
    logic            arvalid_q;
    logic            rready_q;
    logic [1:0]      unused_base;

    assign unused_base = base_addr[1:0];
`else
    logic            unused_rd;

    assign unused_rd = ^{m00_axi_arready, m00_axi_rdata, m00_axi_rresp,
                         m00_axi_rvalid, base_addr[1:0]};
`endif

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef AXI_FREQ_LOADER_READBACK_EN
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= {base_addr[AW-1:2], 2'b00};
                        count_q <= word_count;
                        idx_q   <= '0;
                        err_q   <= 1'b0;
                        if (word_count == 8'd0) begin
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            busy_q    <= 1'b1;
                            s_ready_q <= 1'b1;
                            state_q   <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (s_valid && s_ready_q) begin
                        s_ready_q <= 1'b0;
                        wdata_q   <= s_data;
                        awaddr_q  <= addr_d;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (m00_axi_awready) awvalid_q <= 1'b0;
                    if (m00_axi_wready)  wvalid_q  <= 1'b0;
                    // Both channels done: either already dropped or handshaking now.
                    if ((!awvalid_q || m00_axi_awready) && (!wvalid_q || m00_axi_wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (m00_axi_bvalid) begin
                        bready_q <= 1'b0;
                        if (m00_axi_bresp != 2'b00) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
`ifdef AXI_FREQ_LOADER_READBACK_EN
                            araddr_q  <= awaddr_q;
                            arvalid_q <= 1'b1;
                            state_q   <= S_VERIFY_AR;
`else
                            idx_q <= idx_d;
                            if (last_d) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_FIN;
                            end else begin
                                s_ready_q <= 1'b1;
                                state_q   <= S_FETCH;
                            end
`endif
                        end
                    end
                end
`ifdef AXI_FREQ_LOADER_READBACK_EN
                S_VERIFY_AR: begin
                    if (m00_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_VERIFY_R;
                    end
                end
                S_VERIFY_R: begin
                    if (m00_axi_rvalid) begin
                        rready_q <= 1'b0;
                        if ((m00_axi_rresp != 2'b00) || (m00_axi_rdata != wdata_q)) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            idx_q <= idx_d;
                            if (last_d) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_FIN;
                            end else begin
                                s_ready_q <= 1'b1;
                                state_q   <= S_FETCH;
                            end
                        end
                    end
                end
`endif
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign s_ready         = s_ready_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign m00_axi_awaddr  = awaddr_q;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wdata   = wdata_q;
    assign m00_axi_wstrb   = 4'hF;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = bready_q;
    assign m00_axi_arprot  = 3'b000;
`ifdef AXI_FREQ_LOADER_READBACK_EN
    assign m00_axi_araddr  = araddr_q;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_rready  = rready_q;
`else
    assign m00_axi_araddr  = '0;
    assign m00_axi_arvalid = 1'b0;
    assign m00_axi_rready  = 1'b0;
`endif

endmodule

// File: tb/tb_axi_freq_loader.sv
module tb_axi_freq_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  base_addr;
    logic [7:0]  word_count;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    axi_freq_loader dut (
        .m00_axi_aclk    (clk),
        .m00_axi_aresetn (rst_n),
        .start           (start),
        .base_addr       (base_addr),
        .word_count      (word_count),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .m00_axi_awaddr  (awaddr),
        .m00_axi_awprot  (awprot),
        .m00_axi_awvalid (awvalid),
        .m00_axi_awready (awready),
        .m00_axi_wdata   (wdata),
        .m00_axi_wstrb   (wstrb),
        .m00_axi_wvalid  (wvalid),
        .m00_axi_wready  (wready),
        .m00_axi_bresp   (bresp),
        .m00_axi_bvalid  (bvalid),
        .m00_axi_bready  (bready),
        .m00_axi_araddr  (araddr),
        .m00_axi_arprot  (arprot),
        .m00_axi_arvalid (arvalid),
        .m00_axi_arready (arready),
        .m00_axi_rdata   (rdata),
        .m00_axi_rresp   (rresp),
        .m00_axi_rvalid  (rvalid),
        .m00_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // source and slave model state
    logic [31:0] src_q [0:7];
    int          src_n, src_idx, stall_at, stall_cnt;
    int          w_delay, w_cnt, err_on, corrupt_on, wr_n, rd_n;
    logic        aw_got, w_got, b_arm;
    logic [31:0] last_wdata;
    logic [4:0]  aw_log [0:7];
    logic [31:0] w_log [0:7];
    logic [4:0]  ar_log [0:7];
    int          aw_n, w_n, ar_n;
    int          busy_cyc, done_cyc, aw_hi, w_hi;

    task automatic clear_log();
        src_n = 0; src_idx = 0; stall_at = 0; stall_cnt = 0;
        w_delay = 0; w_cnt = 0; err_on = 0; corrupt_on = 0; wr_n = 0; rd_n = 0;
        aw_got = 1'b0; w_got = 1'b0; b_arm = 1'b0; last_wdata = 32'h0;
        aw_n = 0; w_n = 0; ar_n = 0;
        busy_cyc = 0; done_cyc = 0; aw_hi = 0; w_hi = 0;
        s_valid = 1'b0; s_data = 32'h0;
        awready = 1'b1; wready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b1; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
    endtask

    task automatic load_src(input int n);
        src_n   = n;
        src_idx = 0;
        s_valid = (n > 0);
        s_data  = src_q[0];
    endtask

    // Handshakes are sampled on the falling edge (inputs only change just
    // after the rising edge), then the model reacts after the rising edge.
    initial begin : slave
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs, s_hs;
        forever begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            s_hs  = s_valid && s_ready;
            if (aw_hs && aw_n < 8) begin aw_log[aw_n] = awaddr; aw_n++; end
            if (w_hs && w_n < 8) begin w_log[w_n] = wdata; w_n++; last_wdata = wdata; end
            if (ar_hs && ar_n < 8) begin ar_log[ar_n] = araddr; ar_n++; end
            if (busy)    busy_cyc++;
            if (done)    done_cyc++;
            if (awvalid) aw_hi++;
            if (wvalid)  w_hi++;
            @(posedge clk);
            #1;
            if (s_hs) begin
                src_idx++;
                if (src_idx == stall_at) stall_cnt = 10;
            end else if (stall_cnt > 0) begin
                stall_cnt--;
            end
            s_valid = (src_idx < src_n) && (stall_cnt == 0);
            s_data  = (src_idx < 8) ? src_q[src_idx] : 32'h0;
            if (aw_hs) aw_got = 1'b1;
            if (w_hs) begin
                w_got = 1'b1;
                w_cnt = 0;
            end else if (wvalid) begin
                w_cnt++;
            end
            wready = (w_cnt > w_delay);
            if (b_hs) bvalid = 1'b0;
            if (b_arm) begin
                b_arm  = 1'b0;
                wr_n++;
                bvalid = 1'b1;
                bresp  = (wr_n == err_on) ? 2'b10 : 2'b00;
            end
            if (aw_got && w_got) begin
                b_arm  = 1'b1;
                aw_got = 1'b0;
                w_got  = 1'b0;
            end
            if (r_hs) rvalid = 1'b0;
            if (ar_hs) begin
                rd_n++;
                rvalid = 1'b1;
                rresp  = 2'b00;
                rdata  = last_wdata ^ ((rd_n == corrupt_on) ? 32'h0000_0100 : 32'h0);
            end
        end
    end

    task automatic do_start(input logic [4:0] b, input logic [7:0] n);
        @(posedge clk); #2;
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            cycles++;
            if (done) break;
        end
        check("done_seen", 32'(done), 32'd1);
        check("busy_low_at_done", 32'(busy), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int cyc;

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = 5'h0; word_count = 8'h0;
        clear_log();
        repeat (3) @(negedge clk);
        #1;
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid",  32'(wvalid),  32'd0);
        check("rst_bready",  32'(bready),  32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        check("rst_awaddr",  32'(awaddr),  32'd0);
        check("rst_wdata",   wdata,        32'd0);
        check("rst_read",    {26'd0, araddr, arvalid}, 32'd0);
        check("rst_rready",  32'(rready),  32'd0);
        check("const_prot_strb", {21'd0, awprot, arprot, 1'b0, wstrb}, 32'h0000_000F);
        rst_n = 1'b1;

        // three words, zero-wait slave
        idle_cycles(1);
        clear_log();
        src_q[0] = 32'h11; src_q[1] = 32'h22; src_q[2] = 32'h33;
        load_src(3);
        do_start(5'h00, 8'd3);
        wait_done(200, cyc);
        idle_cycles(3);
        check("t1_nwrites", 32'(aw_n), 32'd3);
        check("t1_addr0", 32'(aw_log[0]), 32'h00);
        check("t1_addr1", 32'(aw_log[1]), 32'h04);
        check("t1_addr2", 32'(aw_log[2]), 32'h08);
        check("t1_data0", w_log[0], 32'h11);
        check("t1_data1", w_log[1], 32'h22);
        check("t1_data2", w_log[2], 32'h33);
        check("t1_done_pulses", 32'(done_cyc), 32'd1);
        check("t1_err", 32'(err), 32'd0);
`ifdef AXI_FREQ_LOADER_READBACK_EN
        check("t1_busy_cycles", 32'(busy_cyc), 32'd18);
        check("t1_reads", 32'(ar_n), 32'd3);
`else
        check("t1_busy_cycles", 32'(busy_cyc), 32'd12);
`endif

        // zero words
        clear_log();
        do_start(5'h04, 8'd0);
        wait_done(20, cyc);
        check("t2_done_latency", 32'(cyc), 32'd1);
        idle_cycles(3);
        check("t2_no_awvalid", 32'(aw_hi), 32'd0);
        check("t2_done_pulses", 32'(done_cyc), 32'd1);
        check("t2_busy_cycles", 32'(busy_cyc), 32'd0);

        // slow wready
        clear_log();
        w_delay = 5;
        src_q[0] = 32'hDEAD_BEEF;
        load_src(1);
        do_start(5'h08, 8'd1);
        wait_done(200, cyc);
        idle_cycles(2);
        check("t3_awvalid_cycles", 32'(aw_hi), 32'd1);
        check("t3_wvalid_cycles", 32'(w_hi), 32'd6);
        check("t3_nwrites", 32'(aw_n * 16 + w_n), 32'h11);
        check("t3_addr", 32'(aw_log[0]), 32'h08);
        check("t3_data", w_log[0], 32'hDEAD_BEEF);

        // error response on second of four words
        clear_log();
        err_on = 2;
        src_q[0] = 32'hA1; src_q[1] = 32'hA2; src_q[2] = 32'hA3; src_q[3] = 32'hA4;
        load_src(4);
        do_start(5'h00, 8'd4);
        wait_done(200, cyc);
        check("t4_err_at_done", 32'(err), 32'd1);
        idle_cycles(4);
        check("t4_nwrites", 32'(aw_n), 32'd2);
        check("t4_words_taken", 32'(src_idx), 32'd2);
        check("t4_done_pulses", 32'(done_cyc), 32'd1);
        check("t4_err_sticky", 32'(err), 32'd1);

        // wrap past the top of the window, source stall mid-sequence
        clear_log();
        stall_at = 1;
        src_q[0] = 32'h100; src_q[1] = 32'h200;
        load_src(2);
        do_start(5'h1C, 8'd2);
        @(negedge clk); #1;
        check("t5_err_cleared", 32'(err), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        idle_cycles(7);
        check("t5_wait_s_ready", 32'(s_ready), 32'd1);
        check("t5_wait_no_bus", {29'd0, awvalid, wvalid, bready}, 32'd0);
        wait_done(200, cyc);
        idle_cycles(2);
        check("t5_addr0", 32'(aw_log[0]), 32'h1C);
        check("t5_addr1", 32'(aw_log[1]), 32'h00);
        check("t5_data1", w_log[1], 32'h200);
        check("t5_awvalid_cycles", 32'(aw_hi), 32'd2);

`ifdef AXI_FREQ_LOADER_READBACK_EN
        // corrupted readback on first word
        clear_log();
        corrupt_on = 1;
        src_q[0] = 32'hC0; src_q[1] = 32'hC1; src_q[2] = 32'hC2;
        load_src(3);
        do_start(5'h0C, 8'd3);
        wait_done(200, cyc);
        idle_cycles(2);
        check("t6_reads", 32'(ar_n), 32'd1);
        check("t6_read_addr", 32'(ar_log[0]), 32'h0C);
        check("t6_err", 32'(err), 32'd1);
        check("t6_nwrites", 32'(aw_n), 32'd1);
`endif

        // reset in the middle of WRITE
        clear_log();
        w_delay = 5;
        src_q[0] = 32'h77;
        load_src(1);
        do_start(5'h04, 8'd1);
        repeat (3) @(negedge clk);
        #1;
        check("t7_in_write", 32'(wvalid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #2;
        check("t7_rst_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
        check("t7_rst_status", {28'd0, s_ready, busy, done, err}, 32'd0);
        check("t7_rst_read", {30'd0, arvalid, rready}, 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        clear_log();
        src_q[0] = 32'h5A;
        load_src(1);
        do_start(5'h10, 8'd1);
        wait_done(200, cyc);
        idle_cycles(2);
        check("t7_after_addr", 32'(aw_log[0]), 32'h10);
        check("t7_after_data", w_log[0], 32'h5A);
        check("t7_after_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/axi_freq_loader.md
# axi_freq_loader

AXI4-Lite initiator that streams a list of 32-bit frequency words into the AXI4-Lite register window of the frequency selector. Words are written to consecutive word addresses starting at a programmable base. It sits in the control fabric between a command/data source (sequencer or host FIFO) and the frequency selector's `s00_axi` slave port. It issues one write at a time and reports completion and bus errors.

## Interface
- C_M00_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_M00_AXI_ADDR_WIDTH, 5, AXI address width in bits.
- m00_axi_aclk  in  1  sole clock; everything is synchronous to its rising edge.
- m00_axi_aresetn  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request to begin a sequence; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  byte address of the first write; bits [1:0] are ignored (forced 0); sampled on accepted start.
- word_count  in  8  number of words to write; sampled on accepted start; 0 is legal.
- s_data  in  32  frequency word from the source.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a sequence.
- err  out  1  sticky error flag; cleared on the next accepted start.
- Write-address channel: m00_axi_awaddr (out, ADDR_WIDTH), m00_axi_awprot (out, 3, constant 3'b000), m00_axi_awvalid (out, 1), m00_axi_awready (in, 1).
- Write-data channel: m00_axi_wdata (out, 32), m00_axi_wstrb (out, 4, constant 4'hF), m00_axi_wvalid (out, 1), m00_axi_wready (in, 1).
- Write-response channel: m00_axi_bresp (in, 2), m00_axi_bvalid (in, 1), m00_axi_bready (out, 1).
- Read channels: m00_axi_araddr (out, ADDR_WIDTH), m00_axi_arprot (out, 3, 3'b000), m00_axi_arvalid (out), m00_axi_arready (in), m00_axi_rdata (in, 32), m00_axi_rresp (in, 2), m00_axi_rvalid (in), m00_axi_rready (out).

## Operation
- FSM states: IDLE → FETCH → WRITE → RESP → (VERIFY_AR → VERIFY_R, only when compiled in) → FETCH or FIN → IDLE.
- IDLE → FETCH on start; latches base_addr and word_count, clears err and the index.
- IDLE → FIN on start with word_count == 0; no bus activity occurs.
- FETCH: s_ready = 1. On handshake, latch s_data and go to WRITE.
- WRITE: awvalid and wvalid rise together.
  - Each drops independently on its own ready handshake.
  - Go to RESP once both handshakes have completed, which may happen in the same cycle or in either order.
- awaddr = base + 4·index, truncated to ADDR_WIDTH. It wraps modulo 2^ADDR_WIDTH; for example, base 0x1C with index 1 gives 0x00.
- RESP: bready = 1.
  - On bvalid with bresp == 2'b00: increment index, then go to FETCH, or to FIN if index reaches word_count.
  - On bvalid with bresp != 2'b00: set err and go to FIN (abort).
- FIN: done = 1 for one cycle; next state is IDLE.
- start outside IDLE is ignored.
- Reset, including mid-transaction: all VALID/READY outputs, busy, done and err = 0 and the state is IDLE on the next edge. The slave-side consequences of an abandoned transaction are not the block's concern.
- Reset values: awaddr/araddr/wdata = 0.

## Timing
- Accepted start at edge t: busy = 1 and s_ready = 1 from t+1.
- s_data accepted at edge t: awvalid/wvalid = 1 from t+1.
- Minimum per-word cost with zero-wait slave: 4 cycles (FETCH, WRITE, RESP, plus one bvalid-latency cycle).
- busy falls in the same cycle done is asserted.
- No combinational path from any input to any AXI output; all outputs are registered.
- VALID signals never depend on READY in the same cycle.

## Configuration
- Macro: AXI_FREQ_LOADER_READBACK_EN.
- Defined:
  - After an OKAY write response, enter VERIFY_AR: arvalid = 1 with araddr = awaddr until arready.
  - Then VERIFY_R: rready = 1 until rvalid.
  - rresp != OKAY or rdata != written word → set err and abort to FIN.
- Undefined: read channels are tied off (arvalid = 0, rready = 0, araddr = 0) and the VERIFY states do not exist.

## Test plan
- base 0x00, count 3, words 0x11,0x22,0x33, zero-wait slave → writes land at 0x00/0x04/0x08, one done pulse, err = 0, busy high 12 cycles.
- count 0 → done one cycle after start; no awvalid ever asserted.
- Slave holds wready 5 cycles after awready → awvalid drops after 1 cycle, wvalid held until wready, single write issued.
- bresp = 2'b10 on the 2nd of 4 words → err = 1, done pulses, only 2 writes seen; next start clears err.
- base 0x1C, count 2 → addresses 0x1C then 0x00 (wrap); s_valid held low 10 cycles mid-sequence → FSM waits in FETCH with no bus activity.
- READBACK_EN defined, slave returns corrupted rdata on word 1 → read issued at the same address, err = 1, sequence aborted after word 1; aresetn pulsed during WRITE → all outputs 0 next edge.
